// File: rtl/patt_pkg.sv
// Shared definitions for the multi-pattern VGA test generator.
//   - Pattern mode encodings selected through mode_i.
//   - 3-bit {R,G,B} colour constants used by the pixel function.
package patt_pkg;

  typedef logic [2:0] rgb_t;

  localparam logic [1:0] MODE_BAND   = 2'd0;
  localparam logic [1:0] MODE_BARS   = 2'd1;
  localparam logic [1:0] MODE_CHECK  = 2'd2;
  localparam logic [1:0] MODE_SCROLL = 2'd3;

  localparam rgb_t BLACK   = 3'b000;
  localparam rgb_t BLUE    = 3'b001;
  localparam rgb_t GREEN   = 3'b010;
  localparam rgb_t CYAN    = 3'b011;
  localparam rgb_t RED     = 3'b100;
  localparam rgb_t MAGENTA = 3'b101;
  localparam rgb_t YELLOW  = 3'b110;
  localparam rgb_t WHITE   = 3'b111;

endpackage

// File: rtl/patt_pixel_fn.sv
// Combinational pixel colour for one coordinate.
// Ports:
//   mode_i    active pattern (registered mode in the top)
//   pos_i     scroll bar left edge (registered position in the top)
//   column_i  current pixel column
//   row_sq_i  row bit that selects the checkerboard square row
//   de_i      active-video enable; black when low
//   rgb_o     {R,G,B} colour
module patt_pixel_fn
  import patt_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int COL_W    = 10,
  parameter int X0       = 213,
  parameter int X1       = 426,
  parameter int SQ_LOG2  = 5,
  parameter int BAR_W    = 64
) (
  input  logic [1:0]       mode_i,
  input  logic [COL_W-1:0] pos_i,
  input  logic [COL_W-1:0] column_i,
  input  logic             row_sq_i,
  input  logic             de_i,
  output rgb_t             rgb_o
);

  localparam int BAR_SPAN = H_ACTIVE / 8;

  logic [2:0]              bar_k;
  logic signed [COL_W+1:0] diff;

  // Colour-bar index from constant edges; columns past the last edge stay in bar 7.
  always_comb begin
    bar_k = '0;
    for (int i = 1; i < 8; i++) begin
      if (int'(column_i) >= i * BAR_SPAN) bar_k = 3'(i);
    end
  end

  // Distance from the bar's left edge, folded into 0..H_ACTIVE-1 so the bar
  // wraps across the right edge of the screen.
  always_comb begin
    diff = $signed({2'b00, column_i}) - $signed({2'b00, pos_i});
    if (diff < 0) diff = diff + $signed((COL_W+2)'(H_ACTIVE));
  end

  always_comb begin
    rgb_o = BLACK;
    if (de_i) begin
      case (mode_i)
        MODE_BAND:  rgb_o = (int'(column_i) > X0 && int'(column_i) < X1) ? RED : GREEN;
        MODE_BARS:  rgb_o = WHITE - bar_k;
        MODE_CHECK: rgb_o = (column_i[SQ_LOG2] ^ row_sq_i) ? WHITE : BLACK;
        default:    rgb_o = (diff < $signed((COL_W+2)'(BAR_W))) ? BLUE : BLACK;
      endcase
    end
  end

endmodule

// File: rtl/patt_gen_multi.sv
// Registered multi-pattern test generator for the VGA display path.
// Produces one {R,G,B} pixel per clock, one cycle after the coordinates.
// Pattern mode and scroll position change only at the end of a frame.
// Ports:
//   clk_i        pixel clock
//   rst_ni       asynchronous active-low reset
//   row_i        current line
//   column_i     current pixel
//   de_i         active-video enable
//   mode_i       requested pattern, sampled at end of frame
//   freeze_i     hold the scroll position at end of frame
//   rgb_o        registered pixel colour
//   de_o         de_i delayed one cycle
//   frame_end_o  one-cycle pulse following the last active pixel
module patt_gen_multi
  import patt_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int COL_W    = 10,
  parameter int ROW_W    = 9,
  parameter int X0       = 213,
  parameter int X1       = 426,
  parameter int SQ_LOG2  = 5,
  parameter int BAR_W    = 64,
  parameter int SPEED    = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [ROW_W-1:0] row_i,
  input  logic [COL_W-1:0] column_i,
  input  logic             de_i,
  input  logic [1:0]       mode_i,
  input  logic             freeze_i,
  output logic [2:0]       rgb_o,
  output logic             de_o,
  output logic             frame_end_o
);

  logic [1:0]       mode_q;
  logic [COL_W-1:0] pos_q;
  logic [COL_W-1:0] pos_next;
  logic [COL_W:0]   pos_sum;
  logic             eof;
  rgb_t             pix_p0;
  rgb_t             rgb_p1;
  logic             vld_p1;
  logic             eof_p1;

  assign eof = de_i && (row_i == ROW_W'(V_ACTIVE - 1)) && (column_i == COL_W'(H_ACTIVE - 1));

  // One extra bit keeps pos_q + SPEED from overflowing before the wrap compare.
  assign pos_sum  = {1'b0, pos_q} + (COL_W+1)'(SPEED);
  assign pos_next = (pos_sum >= (COL_W+1)'(H_ACTIVE))
                  ? COL_W'(pos_sum - (COL_W+1)'(H_ACTIVE))
                  : pos_sum[COL_W-1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q <= MODE_BAND;
      pos_q  <= '0;
    end else if (eof) begin
      mode_q <= mode_i;
      if (!freeze_i) pos_q <= pos_next;
    end
  end

  // Stage p0: pixel function on the incoming coordinate.
  patt_pixel_fn #(
    .H_ACTIVE (H_ACTIVE),
    .COL_W    (COL_W),
    .X0       (X0),
    .X1       (X1),
    .SQ_LOG2  (SQ_LOG2),
    .BAR_W    (BAR_W)
  ) u_pixel_fn (
    .mode_i   (mode_q),
    .pos_i    (pos_q),
    .column_i (column_i),
    .row_sq_i (row_i[SQ_LOG2]),
    .de_i     (de_i),
    .rgb_o    (pix_p0)
  );

  // Stage p1: output register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rgb_p1 <= BLACK;
      vld_p1 <= 1'b0;
      eof_p1 <= 1'b0;
    end else begin
      rgb_p1 <= pix_p0;
      vld_p1 <= de_i;
      eof_p1 <= eof;
    end
  end

  assign rgb_o       = rgb_p1;
  assign de_o        = vld_p1;
  assign frame_end_o = eof_p1;

endmodule

// File: tb/tb_patt_gen_multi.sv
module tb_patt_gen_multi;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [8:0] row;
  logic [9:0] col;
  logic       de;
  logic [1:0] mode;
  logic       freeze;
  logic [2:0] rgb;
  logic       de_out;
  logic       fe;

  int nvec = 0;
  int nmis = 0;
  int exp_pos;

  always #5 clk = ~clk;

  patt_gen_multi dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .row_i       (row),
    .column_i    (col),
    .de_i        (de),
    .mode_i      (mode),
    .freeze_i    (freeze),
    .rgb_o       (rgb),
    .de_o        (de_out),
    .frame_end_o (fe)
  );

  typedef struct {
    string      name;
    int         r;
    int         c;
    logic       d;
    logic [1:0] m;
    logic       f;
    logic [2:0] exp_rgb;
    logic       exp_fe;
  } vec_t;

  vec_t vecs[$];

  task automatic check3(input string name, input logic [2:0] got, input logic [2:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  // Present one coordinate, clock it, and compare all three outputs.
  task automatic pix(input string name, input int r, input int c, input logic d,
                     input logic [1:0] m, input logic f,
                     input logic [2:0] exp_rgb, input logic exp_fe);
    row    = 9'(r);
    col    = 10'(c);
    de     = d;
    mode   = m;
    freeze = f;
    @(posedge clk);
    #1;
    check3(name, rgb, exp_rgb);
    check1({name, "_de"}, de_out, d);
    check1({name, "_fe"}, fe, exp_fe);
  endtask

  task automatic add(input string name, input int r, input int c, input logic d,
                     input logic [1:0] m, input logic f,
                     input logic [2:0] exp_rgb, input logic exp_fe);
    vec_t v;
    v.name = name; v.r = r; v.c = c; v.d = d; v.m = m; v.f = f;
    v.exp_rgb = exp_rgb; v.exp_fe = exp_fe;
    vecs.push_back(v);
  endtask

  // Reference scroll colour: modular distance from the bar's left edge.
  function automatic logic [2:0] scroll_exp(input int c, input int p);
    int d;
    d = (c - p + 640) % 640;
    return (d < 64) ? 3'b001 : 3'b000;
  endfunction

  initial begin
    rst_n = 1'b0; row = 9'd10; col = 10'd300; de = 1'b1; mode = 2'd1; freeze = 1'b0;

    // Band frame after reset (mode 0, pos 0), then bars, checker, scroll.
    add("band_300",   10, 300, 1, 1, 0, 3'b100, 0);
    add("band_100",   10, 100, 1, 1, 0, 3'b010, 0);
    add("band_213",   10, 213, 1, 1, 0, 3'b010, 0);
    add("band_214",   10, 214, 1, 1, 0, 3'b100, 0);
    add("band_425",   10, 425, 1, 1, 0, 3'b100, 0);
    add("band_426",   10, 426, 1, 1, 0, 3'b010, 0);
    add("band_de0",   10, 300, 0, 1, 0, 3'b000, 0);
    add("band_eof",  479, 639, 1, 1, 0, 3'b010, 1);
    add("bars_0",      0,   0, 1, 0, 0, 3'b111, 0);
    add("bars_79",     0,  79, 1, 0, 0, 3'b111, 0);
    add("bars_80",     0,  80, 1, 0, 0, 3'b110, 0);
    add("bars_320",    5, 320, 1, 0, 0, 3'b011, 0);
    add("bars_639",    5, 639, 1, 0, 0, 3'b000, 0);
    add("bars_eof",  479, 639, 1, 2, 0, 3'b000, 1);
    add("chk_0_0",     0,   0, 1, 0, 0, 3'b000, 0);
    add("chk_0_32",    0,  32, 1, 0, 0, 3'b111, 0);
    add("chk_32_32",  32,  32, 1, 0, 0, 3'b000, 0);
    add("chk_32_0",   32,   0, 1, 0, 0, 3'b111, 0);
    add("chk_de0",     0,  32, 0, 0, 0, 3'b000, 0);
    add("chk_eof",   479, 639, 1, 3, 0, 3'b111, 1);
    add("scr_11",      0,  11, 1, 0, 0, 3'b000, 0);
    add("scr_12",      0,  12, 1, 0, 0, 3'b001, 0);
    add("scr_75",      0,  75, 1, 0, 0, 3'b001, 0);
    add("scr_76",      0,  76, 1, 0, 0, 3'b000, 0);
    add("scr_eof",   479, 639, 1, 3, 0, 3'b000, 1);
    add("scr_16",      0,  16, 1, 0, 0, 3'b001, 0);
    add("scr_15",      0,  15, 1, 0, 0, 3'b000, 0);

    // Reset held with de_i=1, mode_i=1.
    repeat (3) @(posedge clk);
    #1;
    check3("rst_rgb", rgb, 3'b000);
    check1("rst_de", de_out, 1'b0);
    check1("rst_fe", fe, 1'b0);
    rst_n = 1'b1;

    foreach (vecs[i])
      pix(vecs[i].name, vecs[i].r, vecs[i].c, vecs[i].d, vecs[i].m, vecs[i].f,
          vecs[i].exp_rgb, vecs[i].exp_fe);

    // Scroll to the wrap position.
    exp_pos = 16;
    while (exp_pos != 636) begin
      pix("scr_step_eof", 479, 639, 1, 3, 0, scroll_exp(639, exp_pos), 1);
      exp_pos = (exp_pos + 4) % 640;
    end
    pix("wrap_636", 1, 636, 1, 3, 0, 3'b001, 0);
    pix("wrap_639", 1, 639, 1, 3, 0, 3'b001, 0);
    pix("wrap_0",   1,   0, 1, 3, 0, 3'b001, 0);
    pix("wrap_59",  1,  59, 1, 3, 0, 3'b001, 0);
    pix("wrap_60",  1,  60, 1, 3, 0, 3'b000, 0);
    pix("wrap_635", 1, 635, 1, 3, 0, 3'b000, 0);
    pix("wrap_eof", 479, 639, 1, 3, 0, 3'b001, 1);
    exp_pos = 0;
    pix("pos0_0",  1,  0, 1, 3, 0, 3'b001, 0);
    pix("pos0_63", 1, 63, 1, 3, 0, 3'b001, 0);
    pix("pos0_64", 1, 64, 1, 3, 0, 3'b000, 0);

    // A full cycle of 160 frames returns the bar to column 0.
    for (int i = 0; i < 160; i++) begin
      pix("cyc_eof", 479, 639, 1, 3, 0, scroll_exp(639, exp_pos), 1);
      exp_pos = (exp_pos + 4) % 640;
    end
    pix("cyc_0",  2,  0, 1, 3, 0, 3'b001, 0);
    pix("cyc_3",  2,  3, 1, 3, 0, 3'b001, 0);
    pix("cyc_63", 2, 63, 1, 3, 0, 3'b001, 0);
    pix("cyc_64", 2, 64, 1, 3, 0, 3'b000, 0);

    // Freeze across two end-of-frame strobes.
    pix("frz_eof1", 479, 639, 1, 3, 1, 3'b000, 1);
    pix("frz_5",      0,   5, 1, 3, 1, 3'b001, 0);
    pix("frz_eof2", 479, 639, 1, 3, 1, 3'b000, 1);
    pix("frz_63",     0,  63, 1, 3, 1, 3'b001, 0);
    pix("frz_64",     0,  64, 1, 3, 1, 3'b000, 0);
    pix("nodepos",  479, 639, 0, 1, 0, 3'b000, 0);
    pix("nodepos_63", 0,  63, 1, 1, 0, 3'b001, 0);
    pix("nodepos_64", 0,  64, 1, 1, 0, 3'b000, 0);
    pix("frz_mode_eof", 479, 639, 1, 1, 1, 3'b000, 1);
    pix("frz_mode_0",     0,   0, 1, 3, 1, 3'b111, 0);
    pix("to_band_eof",  479, 639, 1, 0, 1, 3'b000, 1);

    // Mode request toggled mid-frame; only the value at end of frame counts.
    pix("tog_300", 3, 300, 1, 2, 0, 3'b100, 0);
    pix("tog_100", 3, 100, 1, 0, 0, 3'b010, 0);
    pix("tog_eof", 479, 639, 1, 2, 0, 3'b010, 1);
    pix("tog_chk32", 0, 32, 1, 0, 0, 3'b111, 0);
    pix("tog_chk0",  0,  0, 1, 0, 0, 3'b000, 0);

    // Mid-frame asynchronous reset with a non-zero scroll position.
    pix("pre_eof", 479, 639, 1, 3, 0, 3'b111, 1);
    pix("pre_10",    0,  10, 1, 3, 0, 3'b001, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check3("arst_rgb", rgb, 3'b000);
    check1("arst_de", de_out, 1'b0);
    @(posedge clk);
    #1;
    check3("arst_hold_rgb", rgb, 3'b000);
    check1("arst_hold_de", de_out, 1'b0);
    rst_n = 1'b1;
    pix("post_300", 0, 300, 1, 3, 0, 3'b100, 0);
    pix("post_5",   0,   5, 1, 3, 0, 3'b010, 0);
    pix("post_eof", 479, 639, 1, 3, 1, 3'b010, 1);
    pix("post_0",   0,   0, 1, 3, 1, 3'b001, 0);
    pix("post_63",  0,  63, 1, 3, 1, 3'b001, 0);
    pix("post_64",  0,  64, 1, 3, 1, 3'b000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
